// File: rtl/pipe_hazard_ctrl_if.sv
// Control bundle between the pipeline hazard controller and the datapath.
// The master side is the controller. The slave side is the datapath, which
// supplies the hazard sources and consumes the enables and mux selects.
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = 4,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use1;
    logic              id_use2;
    logic              id_halt;
    logic [REG_AW-1:0] ex_rs1;
    logic [REG_AW-1:0] ex_rs2;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_wen;
    logic              ex_load;
    logic              ex_br_taken;
    logic [REG_AW-1:0] mem_rd;
    logic              mem_wen;
    logic [REG_AW-1:0] wb_rd;
    logic              wb_wen;
    logic              mem_busy;

    logic              pc_we;
    logic              pc_sel_br;
    logic              ifid_we;
    logic              ifid_flush;
    logic              idex_flush;
    logic              exmem_we;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic              halted;
    logic              fault;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        input  id_rs1, id_rs2, id_use1, id_use2, id_halt,
        input  ex_rs1, ex_rs2, ex_rd, ex_wen, ex_load, ex_br_taken,
        input  mem_rd, mem_wen, wb_rd, wb_wen, mem_busy,
        output pc_we, pc_sel_br, ifid_we, ifid_flush, idex_flush, exmem_we,
        output fwd_a, fwd_b, halted, fault, stall_cnt, flush_cnt
    );

    modport slave (
        output id_rs1, id_rs2, id_use1, id_use2, id_halt,
        output ex_rs1, ex_rs2, ex_rd, ex_wen, ex_load, ex_br_taken,
        output mem_rd, mem_wen, wb_rd, wb_wen, mem_busy,
        input  pc_we, pc_sel_br, ifid_we, ifid_flush, idex_flush, exmem_we,
        input  fwd_a, fwd_b, halted, fault, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central 5-stage pipeline controller: load-use stalls, taken-branch flushes,
// D-memory wait states with timeout fault, HALT, and ALU operand forwarding.
module pipe_hazard_ctrl #(
    parameter int REG_AW      = 4,
    parameter int MEM_TIMEOUT = 8,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipe_hazard_ctrl_if.master   bus
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {RUN, MWAIT, HALT} state_t;

    state_t             state, state_next;
    logic [WAIT_W-1:0]  wait_q, wait_next;
    logic [CNT_W-1:0]   stall_q, flush_q;
    logic               halted_q, fault_q;
    logic               stall_inc, flush_inc, fault_set;
    logic               load_use;

    // Load-use hazard: the ID instruction needs a value still being loaded in EX
    always_comb begin
        load_use = bus.ex_load && bus.ex_wen && (bus.ex_rd != REG_AW'(0)) &&
                   ((bus.id_use1 && (bus.id_rs1 == bus.ex_rd)) ||
                    (bus.id_use2 && (bus.id_rs2 == bus.ex_rd)));
    end

    // Operand forwarding selects, EX/MEM result preferred over MEM/WB
    always_comb begin
        bus.fwd_a = 2'b00;
        bus.fwd_b = 2'b00;
        if (bus.mem_wen && (bus.mem_rd != REG_AW'(0)) && (bus.mem_rd == bus.ex_rs1))
            bus.fwd_a = 2'b01;
        else if (bus.wb_wen && (bus.wb_rd != REG_AW'(0)) && (bus.wb_rd == bus.ex_rs1))
            bus.fwd_a = 2'b10;
        if (bus.mem_wen && (bus.mem_rd != REG_AW'(0)) && (bus.mem_rd == bus.ex_rs2))
            bus.fwd_b = 2'b01;
        else if (bus.wb_wen && (bus.wb_rd != REG_AW'(0)) && (bus.wb_rd == bus.ex_rs2))
            bus.fwd_b = 2'b10;
    end

    // Next-state and pipeline enables; everything is held off while in reset
    always_comb begin
        state_next     = state;
        wait_next      = wait_q;
        stall_inc      = 1'b0;
        flush_inc      = 1'b0;
        fault_set      = 1'b0;
        bus.pc_we      = 1'b0;
        bus.pc_sel_br  = 1'b0;
        bus.ifid_we    = 1'b0;
        bus.ifid_flush = 1'b0;
        bus.idex_flush = 1'b0;
        bus.exmem_we   = 1'b0;
        if (rst_n) begin
            case (state)
                HALT: begin
                    bus.idex_flush = 1'b1;
                    bus.exmem_we   = !fault_q;
                end
                default: begin
                    if (bus.mem_busy) begin
                        stall_inc = 1'b1;
                        if (state == RUN) begin
                            state_next = MWAIT;
                            wait_next  = WAIT_W'(1);
                        end else if ((int'(wait_q) + 1) >= MEM_TIMEOUT) begin
                            fault_set  = 1'b1;
                            state_next = HALT;
                        end else begin
                            wait_next = wait_q + WAIT_W'(1);
                        end
                    end else begin
                        state_next = RUN;
                        wait_next  = '0;
                        if (bus.ex_br_taken) begin
                            bus.pc_we      = 1'b1;
                            bus.pc_sel_br  = 1'b1;
                            bus.ifid_we    = 1'b1;
                            bus.ifid_flush = 1'b1;
                            bus.idex_flush = 1'b1;
                            bus.exmem_we   = 1'b1;
                            flush_inc      = 1'b1;
                        end else if (load_use) begin
                            bus.idex_flush = 1'b1;
                            bus.exmem_we   = 1'b1;
                            stall_inc      = 1'b1;
                        end else if (bus.id_halt) begin
                            bus.idex_flush = 1'b1;
                            bus.exmem_we   = 1'b1;
                            state_next     = HALT;
                        end else begin
                            bus.pc_we    = 1'b1;
                            bus.ifid_we  = 1'b1;
                            bus.exmem_we = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // State, wait counter and sticky halted/fault flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_q   <= '0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state    <= state_next;
            wait_q   <= wait_next;
            halted_q <= (state_next == HALT);
            fault_q  <= fault_q || fault_set;
        end
    end

    // Saturating stall and flush performance counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_inc && (stall_q != '1))
                stall_q <= stall_q + CNT_W'(1);
            if (flush_inc && (flush_q != '1))
                flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign bus.halted    = halted_q;
    assign bus.fault     = fault_q;
    assign bus.stall_cnt = stall_q;
    assign bus.flush_cnt = flush_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_pipe_hazard_ctrl;
    localparam int AW          = 4;
    localparam int MEM_TIMEOUT = 8;
    localparam int CNT_W       = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [AW-1:0] id_rs1;
        logic [AW-1:0] id_rs2;
        logic          id_use1;
        logic          id_use2;
        logic          id_halt;
        logic [AW-1:0] ex_rs1;
        logic [AW-1:0] ex_rs2;
        logic [AW-1:0] ex_rd;
        logic          ex_wen;
        logic          ex_load;
        logic          ex_br_taken;
        logic [AW-1:0] mem_rd;
        logic          mem_wen;
        logic [AW-1:0] wb_rd;
        logic          wb_wen;
        logic          mem_busy;
    } stim_t;

    logic clk;
    logic rst_n;
    int   check_count;
    int   pass_count;

    // Behavioural model: consecutive busy cycles, lifetime event counts, halt flags
    int   m_stall;
    int   m_flush;
    int   m_busy_run;
    bit   m_halted;
    bit   m_fault;

    pipe_hazard_ctrl_if #(.REG_AW(AW), .CNT_W(CNT_W)) bus ();

    pipe_hazard_ctrl #(
        .REG_AW(AW), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input int actual, input int expected);
        check_count++;
        if (actual == expected) pass_count++;
        else $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    endtask

    task automatic apply_stimulus(input stim_t s);
        bus.id_rs1 = s.id_rs1;   bus.id_rs2 = s.id_rs2;
        bus.id_use1 = s.id_use1; bus.id_use2 = s.id_use2; bus.id_halt = s.id_halt;
        bus.ex_rs1 = s.ex_rs1;   bus.ex_rs2 = s.ex_rs2;   bus.ex_rd = s.ex_rd;
        bus.ex_wen = s.ex_wen;   bus.ex_load = s.ex_load; bus.ex_br_taken = s.ex_br_taken;
        bus.mem_rd = s.mem_rd;   bus.mem_wen = s.mem_wen;
        bus.wb_rd = s.wb_rd;     bus.wb_wen = s.wb_wen;   bus.mem_busy = s.mem_busy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    function automatic bit model_load_use();
        bit hit1, hit2;
        hit1 = bus.id_use1 && bus.id_rs1 == bus.ex_rd;
        hit2 = bus.id_use2 && bus.id_rs2 == bus.ex_rd;
        return bus.ex_load && bus.ex_wen && bus.ex_rd != 0 && (hit1 || hit2);
    endfunction

    function automatic int model_fwd(input logic [AW-1:0] src);
        if (src == 0) return 0;
        if (bus.mem_wen && bus.mem_rd == src) return 1;
        if (bus.wb_wen && bus.wb_rd == src) return 2;
        return 0;
    endfunction

    // {pc_we, pc_sel_br, ifid_we, ifid_flush, idex_flush, exmem_we}
    function automatic int model_ctrl();
        if (!rst_n) return 6'b000000;
        if (m_halted) return m_fault ? 6'b000010 : 6'b000011;
        if (bus.mem_busy) return 6'b000000;
        if (bus.ex_br_taken) return 6'b111111;
        if (model_load_use()) return 6'b000011;
        if (bus.id_halt) return 6'b000011;
        return 6'b101001;
    endfunction

    function automatic int sat(input int v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    // Advance the model on each active edge using the inputs of the ending cycle
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_stall    <= 0;
            m_flush    <= 0;
            m_busy_run <= 0;
            m_halted   <= 1'b0;
            m_fault    <= 1'b0;
        end else if (!m_halted) begin
            if (bus.mem_busy) begin
                m_stall    <= m_stall + 1;
                m_busy_run <= m_busy_run + 1;
                if (m_busy_run + 1 >= MEM_TIMEOUT) begin
                    m_fault  <= 1'b1;
                    m_halted <= 1'b1;
                end
            end else begin
                m_busy_run <= 0;
                if (bus.ex_br_taken) m_flush <= m_flush + 1;
                else if (model_load_use()) m_stall <= m_stall + 1;
                else if (bus.id_halt) m_halted <= 1'b1;
            end
        end
    end

    // Compare every DUT output against the model mid-cycle
    always @(negedge clk) begin
        check_output("ctrl", int'({bus.pc_we, bus.pc_sel_br, bus.ifid_we,
                     bus.ifid_flush, bus.idex_flush, bus.exmem_we}), model_ctrl());
        check_output("fwd_a", int'(bus.fwd_a), model_fwd(bus.ex_rs1));
        check_output("fwd_b", int'(bus.fwd_b), model_fwd(bus.ex_rs2));
        check_output("halted", int'(bus.halted), int'(m_halted));
        check_output("fault", int'(bus.fault), int'(m_fault));
        check_output("stall_cnt", int'(bus.stall_cnt), sat(m_stall));
        check_output("flush_cnt", int'(bus.flush_cnt), sat(m_flush));
    end

    task automatic reset_dut();
        stim_t s;
        s = '0;
        apply_stimulus(s);
        rst_n = 1'b0;
        settle();
        check_output("rst_pc_we", int'(bus.pc_we), 0);
        check_output("rst_exmem_we", int'(bus.exmem_we), 0);
        check_output("rst_stall_cnt", int'(bus.stall_cnt), 0);
        check_output("rst_halted", int'(bus.halted), 0);
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        stim_t s;
        check_count = 0;
        pass_count  = 0;
        rst_n = 1'b0;
        s = '0;
        apply_stimulus(s);
        tick();
        reset_dut();

        // Idle pipe: everything advances
        tick();
        settle();
        check_output("idle_pc_we", int'(bus.pc_we), 1);
        check_output("idle_ifid_we", int'(bus.ifid_we), 1);

        // Load-use: LW R3 in EX, ADD reading R3 in ID
        tick();
        s = '0; s.ex_load = 1; s.ex_wen = 1; s.ex_rd = 3; s.id_use1 = 1; s.id_rs1 = 3;
        apply_stimulus(s);
        settle();
        check_output("lu_pc_we", int'(bus.pc_we), 0);
        check_output("lu_ifid_we", int'(bus.ifid_we), 0);
        check_output("lu_idex_flush", int'(bus.idex_flush), 1);
        tick();
        s = '0; s.ex_rs1 = 3; s.wb_wen = 1; s.wb_rd = 3;
        apply_stimulus(s);
        settle();
        check_output("lu_fwd_a", int'(bus.fwd_a), 2);
        check_output("lu_resume_pc_we", int'(bus.pc_we), 1);
        check_output("lu_stall_cnt", int'(bus.stall_cnt), 1);

        // Taken branch overrides a simultaneous load-use
        tick();
        s = '0; s.ex_load = 1; s.ex_wen = 1; s.ex_rd = 3; s.id_use2 = 1; s.id_rs2 = 3;
        s.ex_br_taken = 1;
        apply_stimulus(s);
        settle();
        check_output("br_pc_sel_br", int'(bus.pc_sel_br), 1);
        check_output("br_ifid_flush", int'(bus.ifid_flush), 1);
        check_output("br_pc_we", int'(bus.pc_we), 1);
        tick();
        s = '0;
        apply_stimulus(s);
        settle();
        check_output("br_stall_cnt", int'(bus.stall_cnt), 1);
        check_output("br_flush_cnt", int'(bus.flush_cnt), 1);

        // Forwarding priority and register zero
        s = '0; s.mem_wen = 1; s.mem_rd = 5; s.wb_wen = 1; s.wb_rd = 5; s.ex_rs2 = 5;
        apply_stimulus(s);
        settle();
        check_output("fwd_b_mem", int'(bus.fwd_b), 1);
        s.mem_rd = 0;
        apply_stimulus(s);
        settle();
        check_output("fwd_b_wb", int'(bus.fwd_b), 2);
        s.wb_rd = 0; s.ex_rs2 = 0;
        apply_stimulus(s);
        settle();
        check_output("fwd_b_r0", int'(bus.fwd_b), 0);

        // Three busy cycles then resume
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            tick();
            s = '0; s.mem_busy = 1;
            apply_stimulus(s);
            settle();
            check_output("busy_pc_we", int'(bus.pc_we), 0);
            check_output("busy_exmem_we", int'(bus.exmem_we), 0);
        end
        tick();
        s = '0;
        apply_stimulus(s);
        settle();
        check_output("busy_resume_pc_we", int'(bus.pc_we), 1);
        check_output("busy_stall_cnt", int'(bus.stall_cnt), 3);

        // Eight busy cycles trip the timeout fault
        reset_dut();
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            tick();
            s = '0; s.mem_busy = 1;
            apply_stimulus(s);
            settle();
            check_output("to_fault_early", int'(bus.fault), 0);
        end
        tick();
        s = '0;
        apply_stimulus(s);
        settle();
        check_output("to_fault", int'(bus.fault), 1);
        check_output("to_halted", int'(bus.halted), 1);
        check_output("to_exmem_we", int'(bus.exmem_we), 0);
        check_output("to_stall_cnt", int'(bus.stall_cnt), 8);

        // HLT: bubble now, halted next cycle, exit only through reset
        reset_dut();
        tick();
        s = '0; s.id_halt = 1;
        apply_stimulus(s);
        settle();
        check_output("hlt_idex_flush", int'(bus.idex_flush), 1);
        check_output("hlt_pc_we", int'(bus.pc_we), 0);
        check_output("hlt_halted_early", int'(bus.halted), 0);
        tick();
        s = '0; s.ex_br_taken = 1;
        apply_stimulus(s);
        settle();
        check_output("hlt_halted", int'(bus.halted), 1);
        check_output("hlt_exmem_we", int'(bus.exmem_we), 1);
        check_output("hlt_no_branch", int'(bus.pc_sel_br), 0);
        tick();
        tick();
        check_output("hlt_flush_cnt", int'(bus.flush_cnt), 0);
        reset_dut();
        settle();
        check_output("hlt_after_rst", int'(bus.halted), 0);

        // Reset in the middle of a memory stall, with a load-use pending
        tick();
        s = '0; s.mem_busy = 1; s.ex_load = 1; s.ex_wen = 1; s.ex_rd = 2;
        s.id_use1 = 1; s.id_rs1 = 2;
        apply_stimulus(s);
        tick();
        rst_n = 1'b0;
        settle();
        check_output("mid_rst_idex_flush", int'(bus.idex_flush), 0);
        check_output("mid_rst_stall_cnt", int'(bus.stall_cnt), 0);
        tick();
        rst_n = 1'b1;
        s = '0;
        apply_stimulus(s);
        settle();
        check_output("mid_rst_pc_we", int'(bus.pc_we), 1);

        // Stall counter saturation
        reset_dut();
        s = '0; s.ex_load = 1; s.ex_wen = 1; s.ex_rd = 7; s.id_use2 = 1; s.id_rs2 = 7;
        apply_stimulus(s);
        for (int i = 0; i < CNT_MAX; i++) tick();
        settle();
        check_output("sat_full", int'(bus.stall_cnt), 15);
        tick();
        tick();
        settle();
        check_output("sat_hold", int'(bus.stall_cnt), 15);

        tick();
        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central pipeline controller for the 5-stage 16-bit CPU (IF/ID/EX/MEM/WB).
- Decides every cycle whether each pipeline register advances, holds or is bubbled. Handles load-use stalls, taken-branch flushes, D-memory wait states, HALT and operand forwarding selects.
- Sits beside the datapath. It drives the PC write enable, the IF/ID, ID/EX and EX/MEM buffer enables and flushes, and the ALU operand forwarding muxes.

Parameters:
- REG_AW, 4, register address width.
- MEM_TIMEOUT, 8, maximum consecutive mem_busy cycles before a fault is raised.
- CNT_W, 16, width of the stall and flush performance counters.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  asynchronous active-low reset.
- id_rs1  in  REG_AW  source register 1 of the instruction in ID.
- id_rs2  in  REG_AW  source register 2 of the instruction in ID.
- id_use1  in  1  ID instruction reads rs1.
- id_use2  in  1  ID instruction reads rs2.
- id_halt  in  1  ID instruction is HLT.
- ex_rs1  in  REG_AW  rs1 latched in ID/EX.
- ex_rs2  in  REG_AW  rs2 latched in ID/EX.
- ex_rd  in  REG_AW  destination register in ID/EX.
- ex_wen  in  1  ID/EX instruction writes the register file.
- ex_load  in  1  ID/EX instruction is LW.
- ex_br_taken  in  1  branch/jump resolved taken in EX.
- mem_rd  in  REG_AW  destination register in EX/MEM.
- mem_wen  in  1  EX/MEM instruction writes the register file.
- wb_rd  in  REG_AW  destination register in MEM/WB.
- wb_wen  in  1  MEM/WB instruction writes the register file.
- mem_busy  in  1  D-memory not ready this cycle.
- pc_we  out  1  PC register load enable.
- pc_sel_br  out  1  PC loads the branch target instead of PC+1.
- ifid_we  out  1  IF/ID buffer load enable.
- ifid_flush  out  1  IF/ID loads a NOP.
- idex_flush  out  1  ID/EX loads a bubble (all control bits 0).
- exmem_we  out  1  EX/MEM and MEM/WB load enable.
- fwd_a  out  2  ALU A select: 00 register file, 01 EX/MEM, 10 MEM/WB.
- fwd_b  out  2  ALU B select, same encoding as fwd_a.
- halted  out  1  core halted.
- fault  out  1  memory timeout fault (sticky).
- stall_cnt  out  CNT_W  cycles lost to stalls, saturating.
- flush_cnt  out  CNT_W  branch flushes, saturating.

Behaviour:
- States: RUN, MWAIT, HALT. State is encoded in a registered state variable.
- Reset (Rst=0, asynchronous): state=RUN, halted=0, fault=0, both counters=0, wait counter=0.
  - Combinational outputs during reset: pc_we=0, ifid_we=0, exmem_we=0, flushes=0, pc_sel_br=0.
- Register 0 is hardwired zero. It never matches a hazard or forward.
- Hazard terms:
  - load_use = ex_load & ex_wen & ex_rd!=0 & ((id_use1 & id_rs1==ex_rd) | (id_use2 & id_rs2==ex_rd)).
  - fwd_a = 01 if mem_wen & mem_rd!=0 & mem_rd==ex_rs1; else 10 if wb_wen & wb_rd!=0 & wb_rd==ex_rs1; else 00. fwd_b is the same using ex_rs2. EX/MEM has priority.
- Forwarding outputs are combinational and valid in all states.
- RUN priority, highest first:
  1. mem_busy: freeze the whole pipe (pc_we=ifid_we=exmem_we=0, no flushes). Go to MWAIT, wait counter=1, stall_cnt+1.
  2. ex_br_taken: pc_we=1, pc_sel_br=1, ifid_flush=1, idex_flush=1, ifid_we=1, exmem_we=1. flush_cnt+1. Any load_use or id_halt this cycle is ignored, because that instruction is killed.
  3. load_use: pc_we=0, ifid_we=0, idex_flush=1, exmem_we=1. stall_cnt+1. Exactly one bubble is inserted; the next cycle the load is in MEM and forwarding resolves via 10.
  4. id_halt: idex_flush=1, pc_we=0, ifid_we=0, exmem_we=1. Go to HALT next cycle. Older instructions drain.
  5. Otherwise all enables are 1 and all flushes are 0.
- MWAIT:
  - Freeze outputs as in RUN item 1, stall_cnt+1 per cycle.
  - When mem_busy drops, go to RUN; that cycle is evaluated as RUN.
  - If the wait counter reaches MEM_TIMEOUT with mem_busy still 1: fault=1, go to HALT.
- HALT:
  - pc_we=ifid_we=0 and idex_flush=1.
  - exmem_we=1, so in-flight EX/MEM/WB instructions drain. It is 0 if entered through fault.
  - halted=1, registered, asserted the cycle after entry.
  - Exit only via reset.
- Counters saturate at all-ones and never wrap.
- Reset asserted mid-stall or mid-flush: state returns to RUN immediately. No pending bubble survives.

Test Plan:
- LW R3 in EX (ex_load=1, ex_rd=3), ID ADD with id_rs1=3 → one cycle of pc_we=0, ifid_we=0, idex_flush=1. Next cycle with ex_rs1=3, wb_rd=3 → fwd_a=10. stall_cnt=1.
- ex_br_taken=1 together with a load_use condition → pc_sel_br=1, ifid_flush=idex_flush=1, pc_we=1. stall_cnt unchanged, flush_cnt=1.
- mem_wen=1, mem_rd=5 and wb_wen=1, wb_rd=5, ex_rs2=5 → fwd_b=01. With rd=0 → fwd_b=00.
- mem_busy held 3 cycles → 3 frozen cycles, stall_cnt=3, RUN resumes. Held 8 cycles → fault=1, halted=1 the following cycle.
- id_halt=1 → idex_flush=1 that cycle, halted=1 the next cycle. Outputs hold until Rst=0, after which all state and counters are 0.
- Preload stall_cnt to all-ones via 2^CNT_W-1 stall cycles (or CNT_W=4 override) → one more stall leaves it at all-ones.
